alu_iterative: RTL and testbench

Parametrised, registered successor to the MIPS pipeline's combinational ALU. It adds shifts, unsigned compare, signed overflow detection, and an iterative multiply/divide unit that occupies the block for WIDTH cycles. It sits in the EX stage. The pipeline control stalls on `busy__o`, so every operation goes through a start/done handshake.

---
 rtl/alu_iterative.sv | 202 ++++++++++++++++++++
 tb/tb_alu_iterative.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iterative.sv
// alu_iterative: registered EX-stage ALU with an iterative multiply/divide unit.
// Single-cycle ops complete on the accepting edge, so done__o is high in the next cycle.
// MULTU and DIVU (non-zero divisor) take WIDTH more edges and hold busy__o in the meantime.
// Ports:
//   clock__i, reset__i   - clock (rising edge), asynchronous active-high reset
//   start__i             - operation request, sampled only while idle
//   dataA__i, dataB__i   - operands (B[SW-1:0] is the shift amount)
//   ALUCtrl__i           - operation code
//   busy__o, done__o     - multi-cycle op in progress / results just updated
//   ALUResult__o         - result (low product, quotient)
//   ALUResultHi__o       - high product, remainder, else 0
//   Zero__o, Overflow__o, DivByZero__o - status flags for the held result
module alu_iterative #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock__i,
  input  logic             reset__i,
  input  logic             start__i,
  input  logic [WIDTH-1:0] dataA__i,
  input  logic [WIDTH-1:0] dataB__i,
  input  logic [3:0]       ALUCtrl__i,
  output logic             busy__o,
  output logic             done__o,
  output logic [WIDTH-1:0] ALUResult__o,
  output logic [WIDTH-1:0] ALUResultHi__o,
  output logic             Zero__o,
  output logic             Overflow__o,
  output logic             DivByZero__o
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] opnd_b;   // multiplicand or divisor
  logic [WIDTH-1:0] work_hi;  // partial product high / partial remainder
  logic [WIDTH-1:0] work_lo;  // multiplier bits / dividend bits becoming quotient

  // Single-cycle datapath
  logic [SW-1:0]    sh_amt;
  logic [WIDTH-1:0] add_res, sub_res, sra_res;
  logic [WIDTH-1:0] sc_res, sc_hi;
  logic             sc_ovf, sc_dbz;

  assign sh_amt  = dataB__i[SW-1:0];
  assign add_res = dataA__i + dataB__i;
  assign sub_res = dataA__i - dataB__i;
  assign sra_res = WIDTH'($signed(dataA__i) >>> sh_amt);

  always_comb begin
    sc_res = '0;
    sc_hi  = '0;
    sc_ovf = 1'b0;
    sc_dbz = 1'b0;
    case (ALUCtrl__i)
      OP_AND:  sc_res = dataA__i & dataB__i;
      OP_OR:   sc_res = dataA__i | dataB__i;
      OP_XOR:  sc_res = dataA__i ^ dataB__i;
      OP_NOR:  sc_res = ~(dataA__i | dataB__i);
      OP_ADD: begin
        sc_res = add_res;
        sc_ovf = (dataA__i[WIDTH-1] == dataB__i[WIDTH-1]) &&
                 (add_res[WIDTH-1] != dataA__i[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = sub_res;
        sc_ovf = (dataA__i[WIDTH-1] != dataB__i[WIDTH-1]) &&
                 (sub_res[WIDTH-1] != dataA__i[WIDTH-1]);
      end
      OP_SLT:  sc_res = WIDTH'($signed(dataA__i) < $signed(dataB__i));
      OP_SLTU: sc_res = WIDTH'(dataA__i < dataB__i);
      OP_SLL:  sc_res = dataA__i << sh_amt;
      OP_SRL:  sc_res = dataA__i >> sh_amt;
      OP_SRA:  sc_res = sra_res;
      OP_MULTU: sc_res = '0;
      OP_DIVU: begin
        // Only the divide-by-zero case completes here; the iterative path ignores these
        sc_res = '1;
        sc_hi  = dataA__i;
        sc_dbz = 1'b1;
      end
      default: sc_res = WIDTH'(1);
    endcase
  end

  // One shift-add multiply step: add multiplicand if multiplier LSB set, then shift right
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nxt, mul_lo_nxt;

  assign mul_sum    = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd_b} : '0);
  assign mul_hi_nxt = mul_sum[WIDTH:1];
  assign mul_lo_nxt = {mul_sum[0], work_lo[WIDTH-1:1]};

  // One restoring divide step: shift in next dividend bit, subtract divisor if it fits
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff, div_hi_nxt, div_lo_nxt;

  assign div_shift  = {work_hi, work_lo[WIDTH-1]};
  assign div_ge     = div_shift >= {1'b0, opnd_b};
  // Remainder after a successful subtract is below the divisor, so WIDTH bits suffice
  assign div_diff   = div_shift[WIDTH-1:0] - opnd_b;
  assign div_hi_nxt = div_ge ? div_diff : div_shift[WIDTH-1:0];
  assign div_lo_nxt = {work_lo[WIDTH-2:0], div_ge};

  // Control FSM and registered outputs
  always_ff @(posedge clock__i or posedge reset__i) begin
    if (reset__i) begin
      state          <= S_IDLE;
      cnt            <= '0;
      opnd_b         <= '0;
      work_hi        <= '0;
      work_lo        <= '0;
      busy__o        <= 1'b0;
      done__o        <= 1'b0;
      ALUResult__o   <= '0;
      ALUResultHi__o <= '0;
      Zero__o        <= 1'b1;
      Overflow__o    <= 1'b0;
      DivByZero__o   <= 1'b0;
    end else begin
      done__o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start__i) begin
            if (ALUCtrl__i == OP_MULTU) begin
              opnd_b  <= dataA__i;
              work_hi <= '0;
              work_lo <= dataB__i;
              cnt     <= CW'(WIDTH);
              busy__o <= 1'b1;
              state   <= S_MUL;
            end else if (ALUCtrl__i == OP_DIVU && dataB__i != '0) begin
              opnd_b  <= dataB__i;
              work_hi <= '0;
              work_lo <= dataA__i;
              cnt     <= CW'(WIDTH);
              busy__o <= 1'b1;
              state   <= S_DIV;
            end else begin
              ALUResult__o   <= sc_res;
              ALUResultHi__o <= sc_hi;
              Zero__o        <= (sc_res == '0);
              Overflow__o    <= sc_ovf;
              DivByZero__o   <= sc_dbz;
              done__o        <= 1'b1;
            end
          end
        end
        S_MUL: begin
          work_hi <= mul_hi_nxt;
          work_lo <= mul_lo_nxt;
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            ALUResult__o   <= mul_lo_nxt;
            ALUResultHi__o <= mul_hi_nxt;
            Zero__o        <= (mul_lo_nxt == '0);
            Overflow__o    <= 1'b0;
            DivByZero__o   <= 1'b0;
            done__o        <= 1'b1;
            busy__o        <= 1'b0;
            state          <= S_IDLE;
          end
        end
        S_DIV: begin
          work_hi <= div_hi_nxt;
          work_lo <= div_lo_nxt;
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            ALUResult__o   <= div_lo_nxt;
            ALUResultHi__o <= div_hi_nxt;
            Zero__o        <= (div_lo_nxt == '0);
            Overflow__o    <= 1'b0;
            DivByZero__o   <= 1'b0;
            done__o        <= 1'b1;
            busy__o        <= 1'b0;
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iterative.sv
// tb_alu_iterative: scoreboard bench for alu_iterative (WIDTH = 32).
// Expected results are queued when an operation is issued and compared when done__o pulses.
module tb_alu_iterative;

  localparam int unsigned W = 32;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;

  logic          clock__i   = 1'b0;
  logic          reset__i   = 1'b1;
  logic          start__i   = 1'b0;
  logic [W-1:0]  dataA__i   = '0;
  logic [W-1:0]  dataB__i   = '0;
  logic [3:0]    ALUCtrl__i = '0;
  logic          busy__o, done__o, Zero__o, Overflow__o, DivByZero__o;
  logic [W-1:0]  ALUResult__o, ALUResultHi__o;

  alu_iterative #(.WIDTH(W)) dut (
    .clock__i       (clock__i),
    .reset__i       (reset__i),
    .start__i       (start__i),
    .dataA__i       (dataA__i),
    .dataB__i       (dataB__i),
    .ALUCtrl__i     (ALUCtrl__i),
    .busy__o        (busy__o),
    .done__o        (done__o),
    .ALUResult__o   (ALUResult__o),
    .ALUResultHi__o (ALUResultHi__o),
    .Zero__o        (Zero__o),
    .Overflow__o    (Overflow__o),
    .DivByZero__o   (DivByZero__o)
  );

  always #5 clock__i = ~clock__i;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         zero;
    logic         ovf;
    logic         dbz;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model built from plain arithmetic operators
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [2*W-1:0] p;
    e.res = '0; e.hi = '0; e.ovf = 1'b0; e.dbz = 1'b0; e.lat = 1;
    case (op)
      OP_AND:  e.res = a & b;
      OP_OR:   e.res = a | b;
      OP_XOR:  e.res = a ^ b;
      OP_NOR:  e.res = ~(a | b);
      OP_ADD: begin
        e.res = a + b;
        e.ovf = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      OP_SUB: begin
        e.res = a - b;
        e.ovf = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      OP_SLT:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: e.res = (a < b) ? 32'd1 : 32'd0;
      OP_SLL:  e.res = a << b[4:0];
      OP_SRL:  e.res = a >> b[4:0];
      OP_SRA:  e.res = W'($signed(a) >>> b[4:0]);
      OP_MULTU: begin
        p = 64'(a) * 64'(b);
        e.res = p[W-1:0];
        e.hi  = p[2*W-1:W];
        e.lat = W + 1;
      end
      OP_DIVU: begin
        if (b == '0) begin
          e.res = '1;
          e.hi  = a;
          e.dbz = 1'b1;
        end else begin
          e.res = a / b;
          e.hi  = a % b;
          e.lat = W + 1;
        end
      end
      default: e.res = 32'd1;
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation
  always @(negedge clock__i) begin
    if (!reset__i && done__o === 1'b1) begin : mon
      exp_t e;
      check("busy_with_done", 64'(busy__o), 64'd0);
      if (sb.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("result", 64'(ALUResult__o), 64'(e.res));
        check("result_hi", 64'(ALUResultHi__o), 64'(e.hi));
        check("zero", 64'(Zero__o), 64'(e.zero));
        check("overflow", 64'(Overflow__o), 64'(e.ovf));
        check("div_by_zero", 64'(DivByZero__o), 64'(e.dbz));
      end
    end
  end

  // Called at a falling edge; returns at the falling edge where done__o is seen
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit poke);
    exp_t e;
    int   lat;
    int   busy_cnt;
    bit   seen;
    e = model(op, a, b);
    start__i   = 1'b1;
    ALUCtrl__i = op;
    dataA__i   = a;
    dataB__i   = b;
    sb.push_back(e);
    @(posedge clock__i);
    #1;
    start__i   = 1'b0;
    dataA__i   = $urandom;
    dataB__i   = $urandom;
    ALUCtrl__i = 4'($urandom);
    lat = 0; busy_cnt = 0; seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clock__i);
      lat++;
      if (busy__o) busy_cnt++;
      if (done__o) seen = 1'b1;
      else if (poke && lat == 5) begin
        start__i   = 1'b1;
        ALUCtrl__i = OP_ADD;
      end else if (poke && lat == 6) begin
        start__i = 1'b0;
      end
    end
    start__i = 1'b0;
    check("latency", 64'(lat), 64'(e.lat));
    check("busy_cycles", 64'(busy_cnt), 64'(e.lat - 1));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 64'(busy__o), 64'd0);
    check({tag, "_done"}, 64'(done__o), 64'd0);
    check({tag, "_res"}, 64'(ALUResult__o), 64'd0);
    check({tag, "_hi"}, 64'(ALUResultHi__o), 64'd0);
    check({tag, "_zero"}, 64'(Zero__o), 64'd1);
    check({tag, "_ovf"}, 64'(Overflow__o), 64'd0);
    check({tag, "_dbz"}, 64'(DivByZero__o), 64'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int done_cnt;
    logic [3:0] op;
    logic [W-1:0] a, b;

    repeat (3) @(posedge clock__i);
    #1;
    check_reset_state("reset");
    @(negedge clock__i);
    reset__i = 1'b0;

    // Directed cases
    issue(OP_ADD,  32'h7FFFFFFF, 32'h00000001, 1'b0);
    issue(OP_SUB,  32'h00000005, 32'h00000005, 1'b0);
    issue(OP_SUB,  32'h80000000, 32'h00000001, 1'b0);
    issue(OP_ADD,  32'h80000000, 32'h80000000, 1'b0);
    issue(OP_SLT,  32'hFFFFFFFF, 32'h00000001, 1'b0);
    issue(OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    issue(OP_SRA,  32'h80000000, 32'h00000004, 1'b0);
    issue(OP_SLL,  32'h00000001, 32'h00000025, 1'b0);
    issue(OP_SRL,  32'h80000000, 32'h0000001F, 1'b0);
    issue(OP_SRA,  32'h12345678, 32'hFFFFFFE0, 1'b0);
    issue(OP_AND,  32'hF0F0A5A5, 32'h0FF0FFFF, 1'b0);
    issue(OP_OR,   32'hF0000000, 32'h0000000F, 1'b0);
    issue(OP_XOR,  32'hAAAA5555, 32'hFFFF0000, 1'b0);
    issue(OP_NOR,  32'h00000000, 32'h00000000, 1'b0);
    issue(4'b0101, 32'h00000000, 32'h00000000, 1'b0);
    issue(4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    issue(4'b1110, 32'h7FFFFFFF, 32'h00000001, 1'b0);
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    issue(OP_DIVU,  32'd100,      32'd7,        1'b0);
    issue(OP_DIVU,  32'h00001234, 32'h00000000, 1'b0);
    issue(OP_DIVU,  32'h00000003, 32'h00000009, 1'b1);
    issue(OP_MULTU, 32'h00012345, 32'h00006789, 1'b0);
    issue(OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 1'b0);

    // Random mix, back to back
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom >> $urandom_range(0, 31);
      if (i % 7 == 0) b = '0;
      issue(op, a, b, i[0]);
    end

    // Abort a multiply with reset while holding non-zero previous outputs
    issue(OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 1'b0);
    start__i   = 1'b1;
    ALUCtrl__i = OP_MULTU;
    dataA__i   = 32'h3;
    dataB__i   = 32'h4;
    @(posedge clock__i);
    #1;
    start__i = 1'b0;
    repeat (10) @(negedge clock__i);
    #2;
    reset__i = 1'b1;
    #1;
    check_reset_state("abort");
    @(negedge clock__i);
    reset__i = 1'b0;
    done_cnt = 0;
    repeat (40) begin
      @(negedge clock__i);
      if (done__o) done_cnt++;
    end
    check("done_after_abort", 64'(done_cnt), 64'd0);

    issue(OP_ADD, 32'h00000001, 32'h00000002, 1'b0);
    repeat (2) @(negedge clock__i);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
